sync_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller that sequences the dual-port fifomem RAM: owns write/read

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ptr.sv | 15 +
 rtl/sync_fifo_ctrl.sv | 60 ++++++
 tb/tb_sync_fifo_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and threshold legality checks for the FIFO controller
package fifo_pkg;
  localparam int ADDRSIZE_DEF = 4;
  localparam int PTR_W_DEF = ADDRSIZE_DEF + 1;
  localparam int COUNT_W_DEF = ADDRSIZE_DEF + 1;
  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction
  function automatic bit th_ok(input int addrsize, input int afull, input int aempty);
    return afull >= 1 && afull <= fifo_depth(addrsize) && aempty >= 0 && aempty <= fifo_depth(addrsize) - 1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: binary wrap counter with increment and synchronous clear
module fifo_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + W'(1);
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer, occupancy, flag and error control for a first-word-fall-through
// FIFO built around a dual-port RAM with combinational read data
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic                err_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                wclken,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);
  localparam int DEPTH = fifo_depth(ADDRSIZE);
  localparam int CW = ADDRSIZE + 1;
  if (!th_ok(ADDRSIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_th
    $error("sync_fifo_ctrl: AFULL_TH/AEMPTY_TH out of range");
  end
  logic [CW-1:0] wptr, rptr, count_nxt;
  logic wr_ok, rd_ok;
  // rst_n gates the write strobe so reset stops RAM writes in the same cycle
  assign wr_ok = rst_n & push & ~full & ~flush;
  assign rd_ok = pop & ~empty & ~flush;
  assign wclken = wr_ok;
  assign waddr = wptr[ADDRSIZE-1:0];
  assign raddr = rptr[ADDRSIZE-1:0];
  assign count = wptr - rptr;
  assign count_nxt = flush ? '0 : count + CW'(wr_ok) - CW'(rd_ok);
  fifo_ptr #(.W(CW)) u_wptr (.clk(clk), .rst_n(rst_n), .clr(flush), .inc(wr_ok), .ptr(wptr));
  fifo_ptr #(.W(CW)) u_rptr (.clk(clk), .rst_n(rst_n), .clr(flush), .inc(rd_ok), .ptr(rptr));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      full         <= count_nxt == CW'(DEPTH);
      empty        <= count_nxt == '0;
      almost_full  <= count_nxt >= CW'(AFULL_TH);
      almost_empty <= count_nxt <= CW'(AEMPTY_TH);
      overflow     <= ~flush & ((push & full) | (overflow & ~err_clr));
      underflow    <= ~flush & ((pop & empty) | (underflow & ~err_clr));
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed bench with a reference model, a RAM model and a data scoreboard
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n, push, pop, flush, err_clr;
  logic [3:0] waddr, raddr;
  logic wclken, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic [7:0] wdata, rdata, next_d;
  logic [7:0] mem [16];
  logic [7:0] sb [$];
  int checks = 0, errors = 0;
  int m_cnt;
  logic [4:0] m_wp, m_rp;
  logic m_ov, m_un;

  sync_fifo_ctrl #(.ADDRSIZE(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
    .waddr(waddr), .raddr(raddr), .wclken(wclken), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (wclken) mem[waddr] <= wdata;
  assign rdata = mem[raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wp = '0; m_rp = '0; m_ov = 1'b0; m_un = 1'b0;
    sb.delete();
  endtask

  task automatic check_state(input string ph);
    chk({ph, " count"}, count, m_cnt);
    chk({ph, " full"}, full, m_cnt == 16);
    chk({ph, " empty"}, empty, m_cnt == 0);
    chk({ph, " almost_full"}, almost_full, m_cnt >= 14);
    chk({ph, " almost_empty"}, almost_empty, m_cnt <= 2);
    chk({ph, " overflow"}, overflow, m_ov);
    chk({ph, " underflow"}, underflow, m_un);
    chk({ph, " waddr"}, waddr, m_wp[3:0]);
    chk({ph, " raddr"}, raddr, m_rp[3:0]);
  endtask

  task automatic step(input logic p, input logic q, input logic f, input logic e);
    logic wa, ra;
    @(negedge clk);
    push = p; pop = q; flush = f; err_clr = e; wdata = next_d;
    wa = p & (m_cnt != 16) & ~f;
    ra = q & (m_cnt != 0) & ~f;
    #1 chk("wclken", wclken, wa);
    if (ra) chk("rdata", rdata, sb.pop_front());
    if (f) model_reset();
    else begin
      m_ov = (p & (m_cnt == 16)) | (m_ov & ~e);
      m_un = (q & (m_cnt == 0)) | (m_un & ~e);
      if (wa) begin sb.push_back(next_d); m_wp++; next_d++; end
      if (ra) m_rp++;
      m_cnt += int'(wa) - int'(ra);
    end
    @(posedge clk);
    #1 check_state("step");
    push = 0; pop = 0; flush = 0; err_clr = 0;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    push = 1; pop = 0; wdata = next_d;
    #2 rst_n = 0;
    #1 chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst wclken", wclken, 0);
    model_reset();
    check_state("rst");
    @(negedge clk);
    push = 0; rst_n = 1;
  endtask

  initial begin
    rst_n = 0; push = 0; pop = 0; flush = 0; err_clr = 0; wdata = '0; next_d = 8'h01;
    model_reset();
    #12 check_state("reset");
    chk("reset wclken", wclken, 0);
    @(negedge clk) rst_n = 1;
    repeat (16) step(1, 0, 0, 0);
    chk("fill full", full, 1);
    step(1, 0, 0, 0);
    chk("overflow set", overflow, 1);
    chk("overflow count", count, 16);
    step(0, 0, 0, 1);
    chk("err_clr alone", overflow, 0);
    step(1, 0, 0, 1);
    chk("err_clr vs set", overflow, 1);
    step(1, 1, 0, 0);
    chk("full push+pop count", count, 15);
    step(0, 0, 0, 1);
    repeat (15) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("underflow set", underflow, 1);
    step(1, 1, 0, 0);
    chk("empty push+pop count", count, 1);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    repeat (8) step(1, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0);
    repeat (16) step(1, 0, 0, 0);
    chk("wrap full", full, 1);
    chk("wrap raddr", raddr, 8);
    chk("wrap waddr", waddr, 8);
    step(1, 1, 0, 0);
    repeat (10) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("mid push+pop count", count, 5);
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("flush count", count, 0);
    chk("flush empty", empty, 1);
    chk("flush overflow", overflow, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    reset_mid();
    repeat (2) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
